// File: rtl/sprite_line_fetch_if.sv
// Sprite ROM read port and line-buffer write port of the sprite fill stage.
interface sprite_line_fetch_if;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;
  logic        lb_we;
  logic        lb_wbank;
  logic [9:0]  lb_addr;
  logic [23:0] lb_data;

  modport master (
    output rom_addr,
    input  rom_data,
    output lb_we,
    output lb_wbank,
    output lb_addr,
    output lb_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  lb_we,
    input  lb_wbank,
    input  lb_addr,
    input  lb_data
  );
endinterface

// File: rtl/sprite_line_fetch.sv
// Sprite line fill: keeps the shadowed attribute table and, one line ahead of
// the display, clears one line-buffer bank and paints intersecting sprites.
module sprite_line_fetch #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  localparam int unsigned SlotW      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          VGA_HCOUNT,
  input  logic [9:0]          VGA_VCOUNT,
  input  logic                attr_we,
  input  logic [SlotW-1:0]    attr_addr,
  input  logic [23:0]         attr_data,
  sprite_line_fetch_if.master bus,
  output logic                line_done,
  output logic                overrun
);

  typedef enum logic [1:0] {StIdle, StClear, StScan, StFetch} state_e;

  state_e             state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic [9:0]         t_q, t_d;
  logic [4:0]         id_q, id_d;
  logic [4:0]         row_q, row_d;
  logic [9:0]         x_q, x_d;
  logic               line_done_q, line_done_d;
  logic               overrun_q, overrun_d;
  logic [23:0]        pend_q [NUM_SPRITES];
  logic [23:0]        act_q  [NUM_SPRITES];
  logic [14:0]        rom_addr_q;
  logic [9:0]         lb_addr_q;
  logic [23:0]        lb_data_q;

  logic               lb_we;
  logic [9:0]         lb_addr;
  logic [23:0]        lb_data;
  logic [14:0]        rom_addr;

  logic               trigger, abort, copy, last_slot;
  logic [9:0]         tgt;
  logic [23:0]        scan_attr;
  logic [4:0]         scan_id;
  logic [9:0]         scan_dy;
  logic               scan_hit;
  logic [4:0]         fetch_col;
  logic [10:0]        fetch_sum;
  logic               fetch_wr;

  // Line timing decodes and the slot/pixel tests shared by both comb processes
  always_comb begin
    tgt       = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 10'd0 : VGA_VCOUNT + 10'd1;
    trigger   = (VGA_HCOUNT == 10'd0) && (tgt < 10'(V_ACTIVE));
    copy      = (VGA_HCOUNT == 10'd0) && (VGA_VCOUNT == 10'(V_ACTIVE));
    abort     = (VGA_HCOUNT == 10'(H_TOTAL - 1)) && (state_q != StIdle);
    last_slot = (slot_q == '0);
    scan_attr = act_q[slot_q];
    scan_id   = scan_attr[23:19];
    // Modulo-1024 distance; lines above the sprite wrap to large values and miss
    scan_dy   = t_q - {1'b0, scan_attr[18:10]};
    scan_hit  = (scan_id != 5'd0) && (scan_dy < 10'd32);
    // Pixel returning now belongs to the column issued one cycle earlier
    fetch_col = cnt_q[4:0] - 5'd1;
    fetch_sum = {1'b0, x_q} + {6'd0, fetch_col};
    fetch_wr  = (state_q == StFetch) && (cnt_q != 10'd0) && (bus.rom_data != 24'h0) &&
                (fetch_sum < 11'(H_ACTIVE));
  end

  // Attribute table: pending copy written by the CPU, snapshotted into active at vblank
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      if (attr_we) begin
        pend_q[attr_addr] <= attr_data;
      end
      if (copy) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          act_q[i] <= (attr_we && (attr_addr == SlotW'(i))) ? attr_data : pend_q[i];
        end
      end
    end
  end

  // FSM state and fill context registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      slot_q      <= '0;
      t_q         <= '0;
      id_q        <= '0;
      row_q       <= '0;
      x_q         <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      t_q         <= t_d;
      id_q        <= id_d;
      row_q       <= row_d;
      x_q         <= x_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state: clear, then scan slots high to low so slot 0 lands on top
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    t_d         = t_q;
    id_d        = id_q;
    row_d       = row_q;
    x_d         = x_q;
    line_done_d = 1'b0;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StClear;
          cnt_d   = '0;
          t_d     = tgt;
        end
      end
      StClear: begin
        if (cnt_q == 10'(H_ACTIVE - 1)) begin
          state_d = StScan;
          cnt_d   = '0;
          slot_d  = SlotW'(NUM_SPRITES - 1);
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StScan: begin
        if (scan_hit) begin
          state_d = StFetch;
          cnt_d   = '0;
          id_d    = scan_id;
          row_d   = scan_dy[4:0];
          x_d     = scan_attr[9:0];
        end else if (last_slot) begin
          state_d     = StIdle;
          line_done_d = 1'b1;
        end else begin
          slot_d = slot_q - SlotW'(1);
        end
      end
      StFetch: begin
        // Cycle 32 only drains the final ROM read
        if (cnt_q == 10'd32) begin
          if (last_slot) begin
            state_d     = StIdle;
            line_done_d = 1'b1;
          end else begin
            state_d = StScan;
            slot_d  = slot_q - SlotW'(1);
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d     = StIdle;
      line_done_d = 1'b0;
      overrun_d   = 1'b1;
    end
  end

  // Outputs: write strobes per state; address/data buses hold when idle
  always_comb begin
    lb_we    = 1'b0;
    lb_addr  = lb_addr_q;
    lb_data  = lb_data_q;
    rom_addr = rom_addr_q;
    unique case (state_q)
      StClear: begin
        lb_we   = 1'b1;
        lb_addr = cnt_q;
        lb_data = 24'h0;
      end
      StFetch: begin
        if (cnt_q < 10'd32) begin
          rom_addr = {id_q, row_q, cnt_q[4:0]};
        end
        if (fetch_wr) begin
          lb_we   = 1'b1;
          lb_addr = fetch_sum[9:0];
          lb_data = bus.rom_data;
        end
      end
      default: ;
    endcase
    if (abort) begin
      lb_we   = 1'b0;
      lb_addr = lb_addr_q;
      lb_data = lb_data_q;
    end
  end

  // Hold registers so the buses keep their last driven value between writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_addr_q <= '0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else begin
      rom_addr_q <= rom_addr;
      lb_addr_q  <= lb_addr;
      lb_data_q  <= lb_data;
    end
  end

  assign bus.rom_addr = rom_addr;
  assign bus.lb_we    = lb_we;
  assign bus.lb_wbank = t_q[0];
  assign bus.lb_addr  = lb_addr;
  assign bus.lb_data  = lb_data;
  assign line_done    = line_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: line-level reference model of clear/scan/fetch.
module tb_sprite_line_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hc, vc;
  logic        attr_we;
  logic [1:0]  attr_addr;
  logic [23:0] attr_data;
  logic        line_done, overrun;

  sprite_line_fetch_if bus ();

  sprite_line_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .VGA_HCOUNT (hc),
    .VGA_VCOUNT (vc),
    .attr_we    (attr_we),
    .attr_addr  (attr_addr),
    .attr_data  (attr_data),
    .bus        (bus),
    .line_done  (line_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int bank; int addr; int data;} wr_t;
  typedef struct {int cyc; int addr;} ra_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          line_base = 0;
  wr_t         got_wr[$];
  wr_t         exp_wr[$];
  ra_t         exp_ra[$];
  int          got_done[$];
  logic [14:0] rom_tr [0:1023];
  logic [23:0] rom_mem [32768];
  logic [23:0] pend_m [4];
  logic [23:0] act_m  [4];
  bit          ovr_m;
  logic        s_we, s_bank, s_done, s_ovr;
  logic [9:0]  s_addr;
  logic [23:0] s_data;
  logic [14:0] s_ra;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [23:0] mk_attr(input int id, input int y, input int x);
    logic [23:0] a;
    a = {id[4:0], y[8:0], x[9:0]};
    return a;
  endfunction

  // One clock: drive inputs, update the attribute model, sample at negedge, serve ROM
  task automatic step(input int h, input int v, input bit rst_n, input bit we, input int a,
                      input logic [23:0] d);
    wr_t w;
    hc = h[9:0]; vc = v[9:0]; reset = rst_n;
    attr_we = we; attr_addr = a[1:0]; attr_data = d;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin pend_m[i] = '0; act_m[i] = '0; end
      ovr_m = 1'b0;
    end else begin
      if (we) pend_m[a] = d;
      if (h == 0 && v == 480) for (int i = 0; i < 4; i++) act_m[i] = pend_m[i];
    end
    @(negedge clk);
    s_we = bus.lb_we; s_bank = bus.lb_wbank; s_addr = bus.lb_addr; s_data = bus.lb_data;
    s_ra = bus.rom_addr; s_done = line_done; s_ovr = overrun;
    if (s_we === 1'b1) begin
      w.cyc = cyc; w.bank = int'(s_bank); w.addr = int'(s_addr); w.data = int'(s_data);
      got_wr.push_back(w);
    end
    if (s_done === 1'b1) got_done.push_back(cyc);
    if (cyc - line_base >= 0 && cyc - line_base < 1024) rom_tr[cyc - line_base] = s_ra;
    @(posedge clk);
    #1;
    bus.rom_data = rom_mem[s_ra];
    cyc++;
  endtask

  task automatic start_capture();
    got_wr.delete(); got_done.delete(); exp_wr.delete(); exp_ra.delete();
    line_base = cyc;
  endtask

  // Expected write/ROM-address timeline of a fill of line t triggered in cycle tt
  function automatic int build_exp(input int t, input int tt);
    wr_t w;
    ra_t r;
    int  p, id, y, x, dy, pix, ra;
    for (int a = 0; a < 640; a++) begin
      w.cyc = tt + 1 + a; w.bank = t % 2; w.addr = a; w.data = 0;
      exp_wr.push_back(w);
    end
    p = tt + 641;
    for (int s = 3; s >= 0; s--) begin
      id = int'(act_m[s][23:19]); y = int'(act_m[s][18:10]); x = int'(act_m[s][9:0]);
      p++;
      dy = (t - y + 1024) % 1024;
      if (id != 0 && dy < 32) begin
        for (int c = 0; c < 32; c++) begin
          ra = id * 1024 + dy * 32 + c;
          r.cyc = p + c; r.addr = ra;
          exp_ra.push_back(r);
          pix = int'(rom_mem[ra]);
          if (pix != 0 && x + c < 640) begin
            w.cyc = p + c + 1; w.bank = t % 2; w.addr = x + c; w.data = pix;
            exp_wr.push_back(w);
          end
        end
        p += 33;
      end
    end
    return p;
  endfunction

  task automatic compare_line(input string tag, input bit trig, input int exp_done);
    int    nbad, n;
    string first;
    check_eq({tag, "/nwr"}, got_wr.size(), exp_wr.size());
    nbad = 0; first = "";
    n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      if (got_wr[i] != exp_wr[i]) begin
        nbad++;
        if (nbad == 1)
          first = $sformatf(" idx%0d got c%0d b%0d a%0d d%06h exp c%0d b%0d a%0d d%06h", i,
                            got_wr[i].cyc - line_base, got_wr[i].bank, got_wr[i].addr,
                            got_wr[i].data, exp_wr[i].cyc - line_base, exp_wr[i].bank,
                            exp_wr[i].addr, exp_wr[i].data);
      end
    end
    check_eq({tag, "/writes", first}, nbad, 0);
    nbad = 0;
    foreach (exp_ra[i]) if (rom_tr[exp_ra[i].cyc - line_base] !== 15'(exp_ra[i].addr)) nbad++;
    check_eq({tag, "/rom_addr"}, nbad, 0);
    check_eq({tag, "/ndone"}, got_done.size(), trig ? 1 : 0);
    if (trig && got_done.size() > 0)
      check_eq({tag, "/done_cyc"}, got_done[0] - line_base, exp_done - line_base);
    check_eq({tag, "/overrun"}, s_ovr, ovr_m);
  endtask

  task automatic run_line(input string tag, input int v, input int we_h, input int we_a,
                          input logic [23:0] we_d);
    int t, done;
    bit trig;
    start_capture();
    t = (v == 524) ? 0 : v + 1;
    trig = (t < 480);
    done = trig ? build_exp(t, cyc) : 0;
    for (int h = 0; h < 800; h++) begin
      if (h == we_h) step(h, v, 1'b1, 1'b1, we_a, we_d);
      else           step(h, v, 1'b1, 1'b0, 0, 24'h0);
    end
    compare_line(tag, trig, done);
  endtask

  task automatic wr_attr(input int a, input logic [23:0] d);
    step(5, 500, 1'b1, 1'b1, a, d);
  endtask

  task automatic do_copy();
    step(0, 480, 1'b1, 1'b0, 0, 24'h0);
  endtask

  initial begin
    int          n, nlow, t, v, y;
    logic [23:0] img [640];
    for (int i = 0; i < 32768; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
    for (int c = 0; c < 32; c++) rom_mem[1024 + c] = (c == 5) ? 24'h0 : 24'hFF0000;
    for (int i = 0; i < 1024; i++) begin
      rom_mem[2 * 1024 + i] = 24'h00AA11;
      rom_mem[3 * 1024 + i] = 24'h3300BB;
      rom_mem[4 * 1024 + i] = 24'h123456;
    end
    for (int c = 0; c < 32; c++) begin
      rom_mem[6 * 1024 + c] = 24'h0000F0;
      rom_mem[7 * 1024 + c] = 24'h00F000;
    end
    reset = 1'b0; hc = 10'd5; vc = 10'd500; attr_we = 1'b0; attr_addr = '0; attr_data = '0;
    bus.rom_data = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(5, 500, 1'b0, 1'b0, 0, 24'h0);
    step(5, 500, 1'b0, 1'b0, 0, 24'h0);
    step(5, 500, 1'b1, 1'b0, 0, 24'h0);
    check_eq("rst/lb_we", s_we, 0);
    check_eq("rst/lb_wbank", s_bank, 0);
    check_eq("rst/lb_addr", s_addr, 0);
    check_eq("rst/lb_data", s_data, 0);
    check_eq("rst/rom_addr", s_ra, 0);
    check_eq("rst/line_done", s_done, 0);
    check_eq("rst/overrun", s_ovr, 0);

    // Empty table: clear only, done 645 cycles after the trigger
    run_line("blank", 9, -1, 0, 24'h0);
    if (got_done.size() > 0) check_eq("blank/done645", got_done[0] - line_base, 645);

    // Single sprite with a transparent pixel
    wr_attr(0, mk_attr(1, 10, 100));
    do_copy();
    run_line("single", 9, -1, 0, 24'h0);
    n = 0; nlow = 0;
    for (int i = 640; i < got_wr.size(); i++) begin
      n++;
      if (got_wr[i].addr == 105) nlow++;
    end
    check_eq("single/nsprite", n, 31);
    check_eq("single/addr105", nlow, 0);
    check_eq("single/rom_first", rom_tr[645], 15'h0400);
    check_eq("single/rom_last", rom_tr[676], 15'h041F);

    // Priority: slot 1 (B) drawn first, slot 0 (A) ends on top
    wr_attr(0, mk_attr(2, 50, 200));
    wr_attr(1, mk_attr(3, 50, 200));
    do_copy();
    run_line("prio", 55, -1, 0, 24'h0);
    if (got_wr.size() > 640) check_eq("prio/first_B", got_wr[640].data, 24'h3300BB);
    for (int i = 0; i < 640; i++) img[i] = 24'hDEAD00;
    foreach (got_wr[i]) img[got_wr[i].addr] = 24'(got_wr[i].data);
    n = 0;
    for (int a = 200; a < 232; a++) if (img[a] !== 24'h00AA11) n++;
    check_eq("prio/A_on_top", n, 0);

    // Right-edge clipping, no wrap
    wr_attr(0, 24'h0);
    wr_attr(1, 24'h0);
    wr_attr(2, mk_attr(4, 100, 620));
    do_copy();
    run_line("edge", 100, -1, 0, 24'h0);
    n = 0; nlow = 0;
    for (int i = 640; i < got_wr.size(); i++) begin
      n++;
      if (got_wr[i].addr < 12) nlow++;
    end
    check_eq("edge/nsprite", n, 20);
    check_eq("edge/no_wrap", nlow, 0);
    if (got_wr.size() > 0) check_eq("edge/last639", got_wr[got_wr.size() - 1].addr, 639);

    // Target line 501 is outside the active area
    wr_attr(3, mk_attr(5, 470, 0));
    do_copy();
    run_line("notrig", 500, -1, 0, 24'h0);

    // Shadowing: mid-frame writes wait for the copy; copy-cycle write is included
    for (int i = 0; i < 4; i++) wr_attr(i, 24'h0);
    do_copy();
    run_line("shadow_wr", 100, 300, 3, mk_attr(6, 0, 300));
    run_line("shadow_hidden", 10, -1, 0, 24'h0);
    check_eq("shadow/only_clear", got_wr.size(), 640);
    step(0, 480, 1'b1, 1'b1, 2, mk_attr(7, 0, 50));
    run_line("wrap", 524, -1, 0, 24'h0);
    check_eq("wrap/nwr", got_wr.size(), 704);
    if (got_wr.size() > 0) check_eq("wrap/bank0", got_wr[0].bank, 0);

    // Randomized tables and lines
    for (int it = 0; it < 8; it++) begin
      v = ($urandom_range(0, 5) == 0) ? 524 : $urandom_range(0, 478);
      t = (v == 524) ? 0 : v + 1;
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 511);
        else y = (t >= 40) ? t - $urandom_range(0, 40) : $urandom_range(0, t);
        wr_attr(s, mk_attr(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31), y,
                           ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023)
                                                      : $urandom_range(0, 639)));
      end
      do_copy();
      run_line($sformatf("rand%0d", it), v, $urandom_range(1, 799), $urandom_range(0, 3),
               24'($urandom));
    end

    // Overrun: HCOUNT jumps to 700 after the trigger
    for (int s = 0; s < 4; s++) wr_attr(s, mk_attr(s + 1, 190, 100 * s));
    do_copy();
    start_capture();
    step(0, 200, 1'b1, 1'b0, 0, 24'h0);
    for (int h = 700; h < 800; h++) step(h, 200, 1'b1, 1'b0, 0, 24'h0);
    for (int h = 0; h < 40; h++) step(h + 1, 500, 1'b1, 1'b0, 0, 24'h0);
    n = 0;
    foreach (got_wr[i]) if (got_wr[i].cyc >= line_base + 100) n++;
    check_eq("ovr/no_late_writes", n, 0);
    check_eq("ovr/clear_writes", got_wr.size(), 99);
    check_eq("ovr/no_done", got_done.size(), 0);
    check_eq("ovr/sticky_set", s_ovr, 1);
    ovr_m = 1'b1;
    run_line("ovr_after", 300, -1, 0, 24'h0);
    step(5, 500, 1'b0, 1'b0, 0, 24'h0);
    step(5, 500, 1'b1, 1'b0, 0, 24'h0);
    check_eq("ovr/cleared_by_reset", s_ovr, 0);

    // Reset during FETCH
    wr_attr(0, mk_attr(1, 10, 100));
    do_copy();
    start_capture();
    for (int h = 0; h < 700; h++) step(h, 9, (h == 650) ? 1'b0 : 1'b1, 1'b0, 0, 24'h0);
    n = 0;
    foreach (got_wr[i]) if (got_wr[i].cyc > line_base + 650) n++;
    check_eq("rstmid/no_writes", n, 0);
    check_eq("rstmid/no_done", got_done.size(), 0);
    check_eq("rstmid/lb_we", s_we, 0);
    run_line("rstmid_after", 9, -1, 0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
